// File: rtl/cache_pkg.sv
// Shared definitions for the 4-set, 4-word/line direct-mapped data cache and its refill controller.
package cache_pkg;

    localparam int SET_BITS    = 2;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS    = 26;
    localparam int LINE_WORDS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line refill controller: fetches one 16-byte line word by word and pulses fill_valid when complete.
// Optional build macro CRITICAL_WORD_FIRST_EN starts at the missed word and adds crit_valid/crit_data.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [DATA_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic [DATA_WIDTH-1:0] d0,
    output logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] d2,
    output logic [DATA_WIDTH-1:0] d3,
    output logic [TAG_BITS-1:0]   fill_tag,
    output logic [SET_BITS-1:0]   fill_set,
    output logic                  fill_valid,
    output logic                  busy
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data
`endif
);

    localparam int LINE_LSB = OFFSET_BITS + 2;
    localparam int BASE_W   = DATA_WIDTH - LINE_LSB;

    refill_state_t                        state_q, state_d;
    logic [OFFSET_BITS-1:0]               cnt_q, cnt_d;
    logic [OFFSET_BITS-1:0]               rcv_q, rcv_d;
    logic [BASE_W-1:0]                    base_q, base_d;
    logic [WORDS-1:0][DATA_WIDTH-1:0]     line_q, line_d;
    logic [OFFSET_BITS-1:0]               start_word;

    // Byte offset is resolved by the cache; word offset only matters for critical-word-first.
`ifdef CRITICAL_WORD_FIRST_EN
    logic [1:0] unused_byte_bits;
    assign unused_byte_bits = miss_addr[1:0];
    assign start_word       = miss_addr[LINE_LSB-1:2];
`else
    logic [3:0] unused_byte_bits;
    assign unused_byte_bits = miss_addr[LINE_LSB-1:0];
    assign start_word       = '0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rcv_d   = rcv_q;
        base_d  = base_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    base_d  = miss_addr[DATA_WIDTH-1:LINE_LSB];
                    cnt_d   = start_word;
                    rcv_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    line_d[cnt_q] = mem_rdata;
                    cnt_d         = cnt_q + 1'b1;
                    rcv_d         = rcv_q + 1'b1;
                    state_d       = (rcv_q == OFFSET_BITS'(WORDS - 1)) ? DONE : ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rcv_q   <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcv_q   <= rcv_d;
            base_q  <= base_d;
            line_q  <= line_d;
        end
    end

    assign miss_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_rd_en  = (state_q == ISSUE);
    assign fill_valid = (state_q == DONE);

    // Counter wraps within the line, so the address never leaves the aligned 16-byte block.
    assign mem_addr = {base_q, cnt_q, 2'b00};

    assign d0       = line_q[0];
    assign d1       = line_q[1];
    assign d2       = line_q[2];
    assign d3       = line_q[3];
    assign fill_tag = base_q[BASE_W-1:SET_BITS];
    assign fill_set = base_q[SET_BITS-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign crit_valid = (state_q == WAIT) && mem_rvalid && (rcv_q == '0);
    assign crit_data  = crit_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl; memory model returns addr*2. Honours CRITICAL_WORD_FIRST_EN.
module tb_cache_refill_ctrl;

    typedef struct {
        logic [31:0] d [4];
        logic [25:0] tag;
        logic [1:0]  set;
    } fill_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] d0, d1, d2, d3;
    logic [25:0] fill_tag;
    logic [1:0]  fill_set;
    logic        fill_valid;
    logic        busy;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        crit_valid;
    logic [31:0] crit_data;
`endif

    cache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .fill_tag   (fill_tag),
        .fill_set   (fill_set),
        .fill_valid (fill_valid),
        .busy       (busy)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid (crit_valid),
        .crit_data  (crit_data)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd = 0;
    int          n_rvalid = 0;
    int          n_fill = 0;
    int          last_fill_cyc = 0;
    bit          outstanding = 1'b0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [31:0] exp_addr_q [$];
    fill_t       exp_fill_q [$];
    logic [31:0] exp_crit_q [$];
    int          lat_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic fill_t mk_fill(input logic [31:0] w0, w1, w2, w3,
                                      input logic [25:0] tag, input logic [1:0] set);
        fill_t f;
        f.d[0] = w0; f.d[1] = w1; f.d[2] = w2; f.d[3] = w3;
        f.tag  = tag;
        f.set  = set;
        return f;
    endfunction

    // Expected read addresses for the first n words of a refill of addr.
    task automatic expect_reads(input logic [31:0] addr, input int n);
        logic [31:0] base;
        int          start;
        base = {addr[31:4], 4'b0000};
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(addr[3:2]);
        exp_crit_q.push_back((base + 32'(4 * start)) << 1);
`else
        start = 0;
`endif
        for (int i = 0; i < n; i++)
            exp_addr_q.push_back(base + 32'(4 * ((start + i) % 4)));
    endtask

    // Memory model: one response per strobe, data = addr*2, latency from lat_q (default 1).
    initial begin
        logic [31:0] a;
        int          lat;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                a   = mem_addr;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                repeat (lat) @(posedge clk);
                #1 mem_rvalid = 1'b1; mem_rdata = a << 1;
                @(posedge clk);
                #1 mem_rvalid = 1'b0; mem_rdata = '0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                @(posedge clk);
                #1 mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
                @(posedge clk);
                #1 mem_rvalid = 1'b0; mem_rdata = '0;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a read, a fill or a critical word.
    always @(negedge clk) begin
        fill_t       f;
        logic [31:0] e;
        if (mem_rvalid) begin
            n_rvalid++;
            outstanding = 1'b0;
        end
        if (mem_rd_en) begin
            n_rd++;
            check("one_outstanding", 32'(outstanding), 32'd0);
            outstanding = 1'b1;
            if (exp_addr_q.size() == 0) fail("unexpected_mem_rd");
            else begin
                e = exp_addr_q.pop_front();
                check("mem_addr", mem_addr, e);
            end
        end
        if (fill_valid) begin
            n_fill++;
            last_fill_cyc = cyc;
            if (exp_fill_q.size() == 0) fail("unexpected_fill_valid");
            else begin
                f = exp_fill_q.pop_front();
                check("fill_d0", d0, f.d[0]);
                check("fill_d1", d1, f.d[1]);
                check("fill_d2", d2, f.d[2]);
                check("fill_d3", d3, f.d[3]);
                check("fill_tag", 32'(fill_tag), 32'(f.tag));
                check("fill_set", 32'(fill_set), 32'(f.set));
            end
        end
`ifdef CRITICAL_WORD_FIRST_EN
        if (crit_valid) begin
            if (exp_crit_q.size() == 0) fail("unexpected_crit_valid");
            else begin
                e = exp_crit_q.pop_front();
                check("crit_data", crit_data, e);
            end
        end
`endif
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, 32'(miss_ready), 32'd1);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_mem_rd_en"},  32'(mem_rd_en),  32'd0);
        check({tag, "_fill_valid"}, 32'(fill_valid), 32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_d0"}, d0, 32'd0);
        check({tag, "_d1"}, d1, 32'd0);
        check({tag, "_d2"}, d2, 32'd0);
        check({tag, "_d3"}, d3, 32'd0);
        check({tag, "_fill_tag"}, 32'(fill_tag), 32'd0);
        check({tag, "_fill_set"}, 32'(fill_set), 32'd0);
`ifdef CRITICAL_WORD_FIRST_EN
        check({tag, "_crit_valid"}, 32'(crit_valid), 32'd0);
        check({tag, "_crit_data"},  crit_data,       32'd0);
`endif
    endtask

    // Raises miss_valid with addr and returns the cycle number of the accepting cycle.
    task automatic accept(input logic [31:0] addr, output int acc_cyc);
        bit ok = 1'b0;
        miss_valid = 1'b1;
        miss_addr  = addr;
        acc_cyc    = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (miss_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) fail("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fill(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (n_fill >= target) ok = 1'b1;
        end
        if (!ok) fail("fill_timeout");
    endtask

    initial begin
        int acc, acc2, rd0, fill0;
        bit ok;
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle: no reads over 10 cycles.
        rd0 = n_rd;
        repeat (10) @(negedge clk);
        check("idle_no_rd", 32'(n_rd - rd0), 32'd0);
        check("idle_ready", 32'(miss_ready), 32'd1);
        @(posedge clk);
        #1;

        // Miss 0x124, 1-cycle memory latency.
        expect_reads(32'h0000_0124, 4);
        exp_fill_q.push_back(mk_fill(32'h240, 32'h248, 32'h250, 32'h258, 26'h4, 2'd2));
        accept(32'h0000_0124, acc);
        miss_valid = 1'b0;
        wait_fill(1);
        check("latency_min", 32'(last_fill_cyc - acc), 32'd9);
        @(negedge clk);
        check("fill_single_pulse", 32'(fill_valid), 32'd0);
        check("idle_after_done", 32'(miss_ready), 32'd1);
        check("d0_held", d0, 32'h240);
        check("tag_held", 32'(fill_tag), 32'h4);
        @(posedge clk);
        #1;

        // Variable latency 3,1,5,2.
        lat_q = '{3, 1, 5, 2};
        expect_reads(32'h0000_0AB8, 4);
        exp_fill_q.push_back(mk_fill(32'h1560, 32'h1568, 32'h1570, 32'h1578, 26'h2A, 2'd3));
        rd0 = n_rd;
        accept(32'h0000_0AB8, acc);
        miss_valid = 1'b0;
        wait_fill(2);
        check("var_lat_rd_count", 32'(n_rd - rd0), 32'd4);
        check("var_lat_latency", 32'(last_fill_cyc - acc), 32'd16);
        @(posedge clk);
        #1;

        // Stray mem_rvalid while idle.
        rd0   = n_rd;
        fill0 = n_fill;
        stray_req++;
        repeat (6) @(negedge clk);
        check("stray_d0", d0, 32'h1560);
        check("stray_d3", d3, 32'h1578);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_no_fill", 32'(n_fill - fill0), 32'd0);
        check("stray_no_rd", 32'(n_rd - rd0), 32'd0);
        @(posedge clk);
        #1;

        // miss_valid held through the refill; second request 0x40 waits for DONE.
        expect_reads(32'h0000_0124, 4);
        exp_fill_q.push_back(mk_fill(32'h240, 32'h248, 32'h250, 32'h258, 26'h4, 2'd2));
        expect_reads(32'h0000_0040, 4);
        exp_fill_q.push_back(mk_fill(32'h80, 32'h88, 32'h90, 32'h98, 26'h1, 2'd0));
        accept(32'h0000_0124, acc);
        miss_addr = 32'h0000_0040;
        accept(32'h0000_0040, acc2);
        miss_valid = 1'b0;
        check("held_accept_after_done", 32'(acc2 - last_fill_cyc), 32'd1);
        check("held_accept_spacing", 32'(acc2 - acc), 32'd10);
        wait_fill(4);
        @(posedge clk);
        #1;

        // Reset while waiting for the third word.
        lat_q = '{1, 1, 8};
        expect_reads(32'h0000_0200, 3);
        fill0 = n_fill;
        rd0   = n_rd;
        accept(32'h0000_0200, acc);
        miss_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (n_rd - rd0 >= 3) ok = 1'b1;
        end
        if (!ok) fail("third_read_timeout");
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_busy_in_wait", 32'(busy), 32'd1);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_fill", 32'(n_fill - fill0), 32'd0);
        check("abort_idle", 32'(miss_ready), 32'd1);
        @(posedge clk);
        #1;

        // Miss at 0x12C: wraps in critical-word-first builds, same line contents either way.
        expect_reads(32'h0000_012C, 4);
        exp_fill_q.push_back(mk_fill(32'h240, 32'h248, 32'h250, 32'h258, 26'h4, 2'd2));
        accept(32'h0000_012C, acc);
        miss_valid = 1'b0;
        wait_fill(n_fill + 1);
        repeat (3) @(negedge clk);

        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("fill_queue_drained", 32'(exp_fill_q.size()), 32'd0);
`ifdef CRITICAL_WORD_FIRST_EN
        check("crit_queue_drained", 32'(exp_crit_q.size()), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
